multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Main control state machine for the RISC-V multi-cycle core.
- Sequences fetch, decode, execute, memory and writeback for RV32I subset R, I-ALU, LW, SW, B-type, JAL, JALR, LUI.
- Drives datapath mux selects, write enables and alu_op.
- Raises `branch` for the branch-condition unit, which combines it with func3/zero/neg; the datapath forms `pc_write = pc_update | branch_taken`.

Parameters:
- ILLEGAL_HALT, 1: unknown opcode in DECODE goes to HALT (1) or back to FETCH (0).
- STATE_W, 4: state register width; must encode 14 states.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  7  instr[6:0] from instruction register
- pc_update  output  1  unconditional PC write
- branch  output  1  conditional-branch qualifier to branch-condition unit
- adr_src  output  1  memory address: 0=PC, 1=ALUOut
- mem_write  output  1  data memory write enable
- ir_write  output  1  IR and OldPC capture
- reg_write  output  1  register file write
- result_src  output  2  00=ALUOut, 01=mem data, 10=ALU result direct
- alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1, 11=zero
- alu_src_b  output  2  00=rs2, 01=imm, 10=const 4
- alu_op  output  2  00=add, 01=sub (compare), 10=decode by func3/func7
- instr_done  output  1  one-cycle pulse in final state of each instruction
- halted  output  1  FSM in HALT
- state  output  STATE_W  current state, debug only

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While `rst` is high:
  - state forced to FETCH.
  - All outputs are 0, including `state` = FETCH encoding 0 and `halted` = 0; outputs are gated by rst.
- Output style: Moore; every output is a pure function of `state`. The only exception is the MEM_WAIT_EN gating below.
- Any output not listed for a state is 0.
- States, asserted outputs and next state:
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_update=1 -> DECODE.
  - DECODE: a=01, b=01, alu_op=00 (computes branch/JAL target into ALUOut). Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - other -> HALT if ILLEGAL_HALT=1, else FETCH
  - MEM_ADR: a=10, b=01, alu_op=00 -> MEM_READ if opcode=0000011, else MEM_WRITE.
  - MEM_READ: adr_src=1, result_src=00 -> MEM_WB.
  - MEM_WB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
  - MEM_WRITE: adr_src=1, result_src=00, mem_write=1, instr_done=1 -> FETCH.
  - EXEC_R: a=10, b=00, alu_op=10 -> ALU_WB.
  - EXEC_I: a=10, b=01, alu_op=10 -> ALU_WB.
  - ALU_WB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1, instr_done=1 -> FETCH.
  - JALR: a=10, b=01, alu_op=00 (rs1+imm into ALUOut) -> JAL.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 (PC <= ALUOut target, ALU computes OldPC+4) -> ALU_WB.
  - LUI: a=11, b=01, alu_op=00 -> ALU_WB.
  - HALT: halted=1, all other outputs 0; sticky until rst.
- Cycle counts per instruction (FETCH through final state):
  - B: 3
  - R, I, SW, JAL, LUI: 4
  - LW, JALR: 5
- instr_done is high exactly once per instruction and never in HALT.
- Reset mid-instruction: asynchronous return to FETCH with outputs zero. No partial write completes after the rst edge.
- Unused state encodings go to FETCH on the next clock; outputs are 0 while in them.

Optional Feature:
MEM_WAIT_EN:
- Defined: adds input `mem_ready` (1 bit).
  - FETCH, MEM_READ and MEM_WRITE hold until mem_ready=1.
  - In FETCH, ir_write and pc_update are ANDed with mem_ready.
  - In MEM_WRITE, mem_write stays asserted for every wait cycle; instr_done is ANDed with mem_ready.
  - All other outputs stay stable through waits.
- Undefined: port absent; memory is single-cycle and timing is exactly as above.

Test Plan:
- Reset: rst=1 mid-EXEC_R -> all outputs 0 immediately; release -> first cycle FETCH with ir_write=1, pc_update=1.
- R-type: opcode=0110011 -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 and instr_done=1 only in cycle 4; alu_op=10 in cycle 3.
- Loads and stores: opcode=0000011 -> 5 cycles with adr_src=1 in MEM_READ and result_src=01 in MEM_WB. opcode=0100011 -> 4 cycles, mem_write=1 for exactly one cycle.
- Branch and jumps:
  - 1100011 -> 3 cycles, branch=1 with alu_op=01 in cycle 3.
  - 1100111 -> JALR, JAL, ALU_WB with pc_update=1 in the JAL state.
  - 1101111 -> 4 cycles.
- Illegal opcode: 0000000 with ILLEGAL_HALT=1 -> HALT, halted=1, held for 20 cycles until rst. With ILLEGAL_HALT=0 -> back to FETCH in cycle 3, instr_done never asserted.
- MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state held, ir_write=0. LW with 2 wait cycles in MEM_READ -> total 7 cycles.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the RV32I multi-cycle core: fetch/decode/execute/memory/writeback sequencing.
// Optional MEM_WAIT_EN adds mem_ready so FETCH, MEM_READ and MEM_WRITE stall on slow memory.
module multicycle_main_fsm #(
  parameter int ILLEGAL_HALT = 1,
  parameter int STATE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [6:0]         opcode,
  output logic               pc_update,
  output logic               branch,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               instr_done,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_HALT
  } state_e;

  state_e state_q, state_d;
  logic   rdy;

`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  logic       pc_update_d, branch_d, adr_src_d, mem_write_d, ir_write_d, reg_write_d;
  logic       instr_done_d, halted_d;
  logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d, alu_op_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    pc_update_d  = 1'b0;
    branch_d     = 1'b0;
    adr_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    instr_done_d = 1'b0;
    halted_d     = 1'b0;
    result_src_d = 2'b00;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    alu_op_d     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_d   = rdy;
        pc_update_d  = rdy;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
        state_d      = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively form OldPC + imm so BRANCH/JAL find their target in ALUOut.
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
        case (opcode)
          7'b0110011: state_d = S_EXEC_R;
          7'b0010011: state_d = S_EXEC_I;
          7'b0000011,
          7'b0100011: state_d = S_MEM_ADR;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b1100111: state_d = S_JALR;
          7'b0110111: state_d = S_LUI;
          default:    state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        state_d     = (opcode == 7'b0000011) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adr_src_d = 1'b1;
        state_d   = rdy ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        result_src_d = 2'b01;
        reg_write_d  = 1'b1;
        instr_done_d = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src_d    = 1'b1;
        mem_write_d  = 1'b1;
        instr_done_d = rdy;
        state_d      = rdy ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a_d = 2'b10;
        alu_op_d    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        alu_op_d    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_d  = 1'b1;
        instr_done_d = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d  = 2'b10;
        alu_op_d     = 2'b01;
        branch_d     = 1'b1;
        instr_done_d = 1'b1;
      end
      S_JALR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        state_d     = S_JAL;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link value.
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        pc_update_d = 1'b1;
        state_d     = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a_d = 2'b11;
        alu_src_b_d = 2'b01;
        state_d     = S_ALU_WB;
      end
      S_HALT: begin
        halted_d = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_update  = pc_update_d & ~rst;
  assign branch     = branch_d & ~rst;
  assign adr_src    = adr_src_d & ~rst;
  assign mem_write  = mem_write_d & ~rst;
  assign ir_write   = ir_write_d & ~rst;
  assign reg_write  = reg_write_d & ~rst;
  assign instr_done = instr_done_d & ~rst;
  assign halted     = halted_d & ~rst;
  assign result_src = rst ? 2'b00 : result_src_d;
  assign alu_src_a  = rst ? 2'b00 : alu_src_a_d;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_d;
  assign alu_op     = rst ? 2'b00 : alu_op_d;
  assign state      = rst ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: random instruction stream against a per-instruction step model,
// plus reset-in-flight and illegal-opcode checks on ILLEGAL_HALT=1 and ILLEGAL_HALT=0 instances.
module tb_multicycle_main_fsm;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif

  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, instr_done, halted;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  logic       pc_update0, branch0, adr_src0, mem_write0, ir_write0, reg_write0, instr_done0, halted0;
  logic [1:0] result_src0, alu_src_a0, alu_src_b0, alu_op0;
  logic [3:0] state0;

  multicycle_main_fsm #(.ILLEGAL_HALT(1), .STATE_W(4)) dut (
    .clk(clk), .rst(rst),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .opcode(opcode), .pc_update(pc_update), .branch(branch), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .halted(halted), .state(state)
  );

  multicycle_main_fsm #(.ILLEGAL_HALT(0), .STATE_W(4)) dut0 (
    .clk(clk), .rst(rst),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .opcode(opcode), .pc_update(pc_update0), .branch(branch0), .adr_src(adr_src0),
    .mem_write(mem_write0), .ir_write(ir_write0), .reg_write(reg_write0),
    .result_src(result_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .alu_op(alu_op0), .instr_done(instr_done0), .halted(halted0), .state(state0)
  );

  // Output vector: pcu br adr mw irw rw rs[2] a[2] b[2] op[2] done halt
  logic [15:0] got, got0;
  assign got  = {pc_update, branch, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, instr_done, halted};
  assign got0 = {pc_update0, branch0, adr_src0, mem_write0, ir_write0, reg_write0,
                 result_src0, alu_src_a0, alu_src_b0, alu_op0, instr_done0, halted0};

  localparam logic [15:0] V_ZERO = 16'b0_0_0_0_0_0_00_00_00_00_0_0;
  localparam logic [15:0] V_F    = 16'b1_0_0_0_1_0_10_00_10_00_0_0;
  localparam logic [15:0] V_D    = 16'b0_0_0_0_0_0_00_01_01_00_0_0;
  localparam logic [15:0] V_MA   = 16'b0_0_0_0_0_0_00_10_01_00_0_0;
  localparam logic [15:0] V_MR   = 16'b0_0_1_0_0_0_00_00_00_00_0_0;
  localparam logic [15:0] V_MWB  = 16'b0_0_0_0_0_1_01_00_00_00_1_0;
  localparam logic [15:0] V_MWR  = 16'b0_0_1_1_0_0_00_00_00_00_1_0;
  localparam logic [15:0] V_EXR  = 16'b0_0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [15:0] V_EXI  = 16'b0_0_0_0_0_0_00_10_01_10_0_0;
  localparam logic [15:0] V_AWB  = 16'b0_0_0_0_0_1_00_00_00_00_1_0;
  localparam logic [15:0] V_BR   = 16'b0_1_0_0_0_0_00_10_00_01_1_0;
  localparam logic [15:0] V_JALR = 16'b0_0_0_0_0_0_00_10_01_00_0_0;
  localparam logic [15:0] V_JAL  = 16'b1_0_0_0_0_0_00_01_10_00_0_0;
  localparam logic [15:0] V_LUI  = 16'b0_0_0_0_0_0_00_11_01_00_0_0;
  localparam logic [15:0] V_HALT = 16'b0_0_0_0_0_0_00_00_00_00_0_1;

  // scoreboard
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;

  always @(posedge clk) if (!rst && instr_done) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the ordered per-cycle output steps of one instruction.
  task automatic model_instr(input logic [6:0] op);
    exp_q.delete();
    exp_q.push_back(V_F);
    exp_q.push_back(V_D);
    case (op)
      7'b0110011: begin exp_q.push_back(V_EXR); exp_q.push_back(V_AWB); end
      7'b0010011: begin exp_q.push_back(V_EXI); exp_q.push_back(V_AWB); end
      7'b0000011: begin exp_q.push_back(V_MA); exp_q.push_back(V_MR); exp_q.push_back(V_MWB); end
      7'b0100011: begin exp_q.push_back(V_MA); exp_q.push_back(V_MWR); end
      7'b1100011: exp_q.push_back(V_BR);
      7'b1101111: begin exp_q.push_back(V_JAL); exp_q.push_back(V_AWB); end
      7'b1100111: begin exp_q.push_back(V_JALR); exp_q.push_back(V_JAL); exp_q.push_back(V_AWB); end
      default:    begin exp_q.push_back(V_LUI); exp_q.push_back(V_AWB); end
    endcase
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Driver: runs one legal instruction from its FETCH cycle, checking both instances each cycle.
  task automatic run_instr(input logic [6:0] op);
    int n;
    int len;
    int dones;
    opcode = op;
    model_instr(op);
    len = exp_q.size();
    n = 0;
    dones = 0;
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      if (n == 0) check("fetch_state", 32'(state), 32'd0);
      check($sformatf("out op=%b step%0d", op, n), 32'(got), 32'(e));
      check($sformatf("out0 op=%b step%0d", op, n), 32'(got0), 32'(e));
      dones += int'(instr_done);
      n++;
      next_cycle();
    end
    check($sformatf("done_once op=%b len=%0d", op, len), 32'(dones), 32'd1);
    done_exp++;
  endtask

  logic [6:0] ops [8];

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0110111;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_out", 32'(got), 32'(V_ZERO));
    check("reset_state", 32'(state), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_fetch", 32'(got), 32'(V_F));

    // reset in the middle of EXEC_R
    opcode = 7'b0110011;
    next_cycle();
    check("mid_decode", 32'(got), 32'(V_D));
    next_cycle();
    check("mid_exec_r", 32'(got), 32'(V_EXR));
    rst = 1'b1;
    #1;
    check("mid_rst_out", 32'(got), 32'(V_ZERO));
    check("mid_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_release_fetch", 32'(got), 32'(V_F));

    // directed: one of each, then random stream
    for (int i = 0; i < 8; i++) run_instr(ops[i]);
    for (int i = 0; i < 60; i++) run_instr(ops[$urandom_range(0, 7)]);
    check("done_count", 32'(done_seen), 32'(done_exp));

    // illegal opcode: HALT on dut, back to FETCH on dut0
    opcode = 7'b0000000;
    check("ill_fetch", 32'(got), 32'(V_F));
    check("ill0_fetch", 32'(got0), 32'(V_F));
    next_cycle();
    check("ill_decode", 32'(got), 32'(V_D));
    check("ill0_decode", 32'(got0), 32'(V_D));
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt_c%0d", i), 32'(got), 32'(V_HALT));
      check($sformatf("ill0_c%0d", i), 32'(got0), 32'((i % 2 == 0) ? V_F : V_D));
      check($sformatf("ill0_done_c%0d", i), 32'(instr_done0), 32'd0);
      if (i == 0) check("ill0_state_fetch", 32'(state0), 32'd0);
      next_cycle();
    end
    rst = 1'b1;
    #1;
    check("halt_rst_out", 32'(got), 32'(V_ZERO));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("halt_release_fetch", 32'(got), 32'(V_F));
    run_instr(ops[$urandom_range(0, 7)]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
